// File: rtl/axi_slv_pkg.sv
// Shared types and constants for the AXI SRAM slave: FSM states, response codes, burst-length width.
package axi_slv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdData,
    StWrData,
    StWrResp
  } state_e;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam int unsigned LenW = 4;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// INCR beat address and remaining-beat counter for one AXI burst.
module axi_burst_addr_gen
  import axi_slv_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [31:0]     addr_i,
  input  logic [LenW-1:0] len_i,
  input  logic [2:0]      size_i,
  input  logic            step_i,
  output logic [31:0]     addr_o,
  output logic            last_o
);

  logic [31:0]     addr_q;
  logic [LenW-1:0] cnt_q;
  logic [2:0]      size_q;

  // Every burst type is treated as INCR.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cnt_q  <= '0;
      size_q <= '0;
    end else if (load_i) begin
      addr_q <= addr_i;
      cnt_q  <= len_i;
      size_q <= size_i;
    end else if (step_i) begin
      addr_q <= addr_q + (32'd1 << size_q);
      cnt_q  <= cnt_q - LenW'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave in front of a synchronous word SRAM, one transaction at a time, round-robin AR/AW.
// Define AXI_SLV_DECERR_EN to answer out-of-window beats with DECERR instead of wrapping.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [31:0] ADDR_BASE = 32'h1fc0_0000
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [3:0]        arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [3:0]        rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [3:0]        awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [3:0]        wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [3:0]        bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  state_e      state_q, state_d;
  logic        alive_q;
  logic        last_rd_q;
  logic [3:0]  id_q;
  logic        err_q;
  logic        rdata_fresh_q;
  logic [31:0] rdata_q;

  logic        ar_hs, aw_hs, idle;
  logic        gen_step, gen_last;
  logic [31:0] gen_addr, off;
  logic        in_range, wr_oob;

  // alive_q keeps both readies low until the first edge after reset release.
  assign idle    = alive_q && (state_q == StIdle);
  assign arready = idle && (!awvalid || !last_rd_q);
  assign awready = idle && (!arvalid || last_rd_q);
  assign ar_hs   = arvalid && arready;
  assign aw_hs   = awvalid && awready;

  axi_burst_addr_gen u_addr_gen (
    .clk_i  (aclk),
    .rst_ni (aresetn),
    .load_i (ar_hs || aw_hs),
    .addr_i (ar_hs ? araddr : awaddr),
    .len_i  (ar_hs ? arlen[LenW-1:0] : awlen),
    .size_i (ar_hs ? arsize : awsize),
    .step_i (gen_step),
    .addr_o (gen_addr),
    .last_o (gen_last)
  );

  assign off = gen_addr - ADDR_BASE;
`ifdef AXI_SLV_DECERR_EN
  assign in_range = (gen_addr >= ADDR_BASE) && ((off >> (ADDR_W + 2)) == '0);
`else
  assign in_range = 1'b1;
`endif
  assign wr_oob = (state_q == StWrData) && wvalid && !in_range;

  logic unused_sigs;
  assign unused_sigs = ^{arburst, awburst, wid, wlast, arlen[7:LenW], off[31:ADDR_W+2]};

  always_comb begin
    state_d   = state_q;
    gen_step  = 1'b0;
    ram_en    = 1'b0;
    ram_we    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = RespOkay;
    rdata     = '0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = RespOkay;
    unique case (state_q)
      StIdle: begin
        if (ar_hs) begin
          state_d = StRdReq;
        end else if (aw_hs) begin
          state_d = StWrData;
        end
      end
      StRdReq: begin
        ram_en   = in_range;
        ram_addr = off[ADDR_W+1:2];
        state_d  = StRdData;
      end
      StRdData: begin
        rvalid = 1'b1;
        rlast  = gen_last;
        rresp  = in_range ? RespOkay : RespDecerr;
        // SRAM output is live only in the first cycle; afterwards serve the captured copy.
        rdata  = !in_range ? '0 : (rdata_fresh_q ? ram_rdata : rdata_q);
        if (rready) begin
          gen_step = 1'b1;
          state_d  = gen_last ? StIdle : StRdReq;
        end
      end
      StWrData: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_en    = in_range;
          ram_we    = in_range ? wstrb : 4'b0;
          ram_addr  = off[ADDR_W+1:2];
          ram_wdata = wdata;
          gen_step  = 1'b1;
          if (gen_last) begin
            state_d = StWrResp;
          end
        end
      end
      StWrResp: begin
        bvalid = 1'b1;
        bresp  = err_q ? RespDecerr : RespOkay;
        if (bready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= StIdle;
      alive_q       <= 1'b0;
      last_rd_q     <= 1'b0;
      id_q          <= '0;
      err_q         <= 1'b0;
      rdata_fresh_q <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q <= state_d;
      alive_q <= 1'b1;
      if (ar_hs) begin
        last_rd_q <= 1'b1;
        id_q      <= arid;
      end else if (aw_hs) begin
        last_rd_q <= 1'b0;
        id_q      <= awid;
        err_q     <= 1'b0;
      end else if (wr_oob) begin
        err_q <= 1'b1;
      end
      rdata_fresh_q <= (state_q == StRdReq);
      if (rdata_fresh_q) begin
        rdata_q <= ram_rdata;
      end
    end
  end

  assign rid = id_q;
  assign bid = id_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed plus randomized bench for axi_sram_slave against a word-array reference memory.
module tb_axi_sram_slave;

  localparam int unsigned AW    = 16;
  localparam logic [31:0] BASE  = 32'h1fc0_0000;
  localparam int unsigned Words = 1 << AW;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [3:0]    arid, awid, wid, rid, bid;
  logic [31:0]   araddr, awaddr, wdata, rdata, ram_wdata, ram_rdata;
  logic [7:0]    arlen;
  logic [3:0]    awlen, wstrb, ram_we;
  logic [2:0]    arsize, awsize;
  logic [1:0]    arburst, awburst, rresp, bresp;
  logic          arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic          wlast, wvalid, wready, bvalid, bready, ram_en;
  logic [AW-1:0] ram_addr;

  logic [31:0] mem     [Words];
  logic [31:0] ref_mem [Words];
  int checks = 0;
  int failures = 0;
  int ram_en_cnt = 0;
  int wr_cnt = 0;
  int grants[$];

  always #5 aclk = ~aclk;

  axi_sram_slave #(.ADDR_W(AW), .ADDR_BASE(BASE)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 2) return 32'hdead_beef;
    if (i < 1024) return (32'(i) * 32'h9e37_79b9) ^ 32'h0f0f_1234;
    return 32'h0;
  endfunction

  function automatic bit in_map(logic [31:0] a);
`ifdef AXI_SLV_DECERR_EN
    return (a >= BASE) && ((a - BASE) < 32'(4 * Words));
`else
    return 1'b1;
`endif
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'(((a - BASE) >> 2) & 32'(Words - 1));
  endfunction

  // Synchronous SRAM: read data appears the cycle after ram_en with ram_we == 0.
  initial begin
    for (int i = 0; i < Words; i++) mem[i] = init_word(i);
    ram_rdata <= '0;
    forever begin
      @(posedge aclk);
      if (ram_en) begin
        if (ram_we == 4'b0) ram_rdata <= mem[ram_addr];
        else for (int k = 0; k < 4; k++)
          if (ram_we[k]) mem[ram_addr][8*k +: 8] = ram_wdata[8*k +: 8];
      end
    end
  end

  always @(posedge aclk) begin
    if (ram_en) ram_en_cnt <= ram_en_cnt + 1;
    if (ram_en && ram_we != 4'b0) wr_cnt <= wr_cnt + 1;
    if (arvalid && arready) grants.push_back(0);
    if (awvalid && awready) grants.push_back(1);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size);
    bit got = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = 2'($urandom); awvalid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      got = awready;
      tick();
    end
    awvalid = 1'b0;
    chk("aw_handshake", 32'(got), 1);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len8,
                         input logic [2:0] size, input int stall_beat);
    int n, lat, en0;
    bit got;
    logic [31:0] a, ed;
    logic [1:0] er;
    n = int'(len8[3:0]) + 1;
    arid = id; araddr = addr; arlen = len8; arsize = size; arburst = 2'($urandom); arvalid = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = arready;
      tick();
    end
    arvalid = 1'b0;
    chk("ar_handshake", 32'(got), 1);
    for (int b = 0; b < n; b++) begin
      a  = addr + 32'(b) * (32'd1 << size);
      ed = in_map(a) ? ref_mem[widx(a)] : 32'h0;
      er = in_map(a) ? 2'b00 : 2'b11;
      // Handshake cycle is cycle 0; we are now in cycle 1.
      lat = 1;
      got = rvalid;
      while (!got && lat < 20) begin
        tick();
        lat++;
        got = rvalid;
      end
      chk("r_valid", 32'(got), 1);
      if (b == 0) chk("r_first_latency", 32'(lat), 2);
      if (b == stall_beat) begin
        en0 = ram_en_cnt;
        for (int s = 0; s < 5; s++) begin
          chk("r_stall_data", rdata, ed);
          tick();
        end
        chk("r_stall_valid", 32'(rvalid), 1);
        chk("r_stall_ram_en", 32'(ram_en_cnt - en0), 0);
      end
      chk("r_data", rdata, ed);
      chk("r_id", 32'(rid), 32'(id));
      chk("r_resp", 32'(rresp), 32'(er));
      chk("r_last", 32'(rlast), 32'(b == n - 1));
      rready = 1'b1;
      tick();
      rready = 1'b0;
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [3:0] strb, input bit rnd);
    int n, w0, exp_wr, idx;
    bit got, err;
    logic [31:0] a, d;
    logic [3:0] s;
    n = int'(len) + 1;
    err = 0;
    exp_wr = 0;
    w0 = wr_cnt;
    send_aw(id, addr, len, size);
    for (int b = 0; b < n; b++) begin
      a = addr + 32'(b) * (32'd1 << size);
      d = rnd ? $urandom : 32'(b);
      s = rnd ? 4'($urandom) : strb;
      // wlast is advisory only; random values must not change the burst length.
      wdata = d; wstrb = s; wid = id; wvalid = 1'b1;
      wlast = rnd ? 1'($urandom) : (b == n - 1);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        got = wready;
        tick();
      end
      chk("w_ready", 32'(got), 1);
      if (in_map(a)) begin
        idx = widx(a);
        for (int k = 0; k < 4; k++) if (s[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
        if (s != 4'b0) exp_wr++;
      end else begin
        err = 1;
      end
    end
    wvalid = 1'b0;
    wlast = 1'b0;
    got = bvalid;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = bvalid;
    end
    chk("b_valid", 32'(got), 1);
    chk("b_id", 32'(bid), 32'(id));
    chk("b_resp", 32'(bresp), err ? 32'd3 : 32'd0);
    chk("w_ram_writes", 32'(wr_cnt - w0), 32'(exp_wr));
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("b_single", 32'(bvalid), 0);
  endtask

  initial begin
    int w0, en0, bad;
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = '0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    arvalid = 1'b1; awvalid = 1'b1;
    for (int i = 0; i < Words; i++) ref_mem[i] = init_word(i);
    repeat (3) tick();

    chk("rst_ready", 32'({arready, awready}), 0);
    chk("rst_handshake_ctl", 32'({rvalid, bvalid, wready, rlast}), 0);
    chk("rst_ram_ctl", 32'({ram_en, ram_we}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ids_resps", 32'({rid, rresp, bid, bresp}), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    arvalid = 1'b0; awvalid = 1'b0;
    aresetn = 1'b1;
    tick();
    chk("release_ready", 32'({arready, awready}), 32'b11);

    // Both requesters held valid: grants must alternate starting with a read.
    araddr = BASE + 32'h8; arlen = 8'd0; awaddr = BASE + 32'h100; awlen = 4'd0;
    wstrb = 4'b0; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1; bready = 1'b1;
    grants.delete();
    arvalid = 1'b1; awvalid = 1'b1;
    repeat (24) tick();
    arvalid = 1'b0; awvalid = 1'b0;
    repeat (8) tick();
    wvalid = 1'b0; wlast = 1'b0; rready = 1'b0; bready = 1'b0;
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_grant%0d", i), (i < grants.size()) ? 32'(grants[i]) : 32'd2, 32'(i % 2));

    do_read(4'h5, BASE + 32'h8, 8'd0, 3'd2, -1);

    do_write(4'h3, BASE, 4'd3, 3'd2, 4'b0011, 1'b0);
    for (int i = 0; i < 4; i++) chk("w_low_half", 32'(mem[i][15:0]), 32'(i));

    do_read(4'h7, BASE + 32'h20, 8'd3, 3'd2, 1);

    // Reset arrives while beat 2 of a 4-beat write is being offered.
    send_aw(4'h2, BASE + 32'h40, 4'd3, 3'd2);
    for (int b = 0; b < 2; b++) begin
      wdata = $urandom; wstrb = 4'hf; wlast = 1'b0; wvalid = 1'b1;
      tick();
      ref_mem[16 + b] = wdata;
    end
    wdata = $urandom;
    aresetn = 1'b0;
    #1;
    chk("rst_mid_ram_en", 32'(ram_en), 0);
    w0 = wr_cnt;
    repeat (2) tick();
    chk("rst_mid_awready", 32'(awready), 0);
    aresetn = 1'b1;
    tick();
    chk("rst_release_awready", 32'(awready), 1);
    repeat (3) tick();
    wvalid = 1'b0;
    chk("rst_no_write", 32'(wr_cnt - w0), 0);
    for (int i = 16; i < 20; i++) chk("rst_mem_words", mem[i], ref_mem[i]);

    // Below the window: DECERR when enabled, otherwise wraps to word 0 with OKAY.
    en0 = ram_en_cnt;
    do_read(4'h9, 32'h0000_0000, 8'd0, 3'd2, -1);
`ifdef AXI_SLV_DECERR_EN
    chk("decerr_no_ram_en", 32'(ram_en_cnt - en0), 0);
`endif

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 0)
        do_read(4'($urandom), BASE + 32'(4 * $urandom_range(0, 255)), 8'($urandom),
                3'($urandom_range(0, 2)), -1);
      else
        do_write(4'($urandom), BASE + 32'(4 * $urandom_range(0, 255)), 4'($urandom),
                 3'($urandom_range(0, 2)), 4'b0, 1'b1);
    end

    bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", 32'(bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
